// File: rtl/mont_exp_ctrl.sv
// mont_exp_ctrl: sequencer for left-to-right square-and-multiply
// exponentiation in the Montgomery domain, A~ = X~^E mod M.
// It performs no arithmetic. Every product is requested from one external
// Montgomery multiplier through mm_start/mm_a/mm_b/mm_m, and the answer
// comes back on mm_result/mm_done.
// Optional feature: define MONT_EXP_FROMMONT_EN to add one final
// multiplication by 1 after the scan. That call converts the result back
// to the normal domain, so the output is X^E mod M. When the macro is not
// defined, the output is X^E*R mod M.
module mont_exp_ctrl #(
    parameter int WIDTH  = 512,
    parameter int ELEN_W = 10
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [WIDTH-1:0]  in_x,
    input  logic [WIDTH-1:0]  in_r,
    input  logic [WIDTH-1:0]  in_m,
    input  logic [WIDTH-1:0]  in_e,
    input  logic [ELEN_W-1:0] in_elen,
    output logic              mm_start,
    output logic [WIDTH-1:0]  mm_a,
    output logic [WIDTH-1:0]  mm_b,
    output logic [WIDTH-1:0]  mm_m,
    input  logic [WIDTH-1:0]  mm_result,
    input  logic              mm_done,
    output logic [WIDTH-1:0]  result,
    output logic              busy,
    output logic              done
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SQ_GO,
        ST_SQ_WAIT,
        ST_MUL_GO,
        ST_MUL_WAIT,
        ST_CONV_GO,
        ST_CONV_WAIT,
        ST_FINAL,
        ST_DONE
    } state_t;

    localparam logic [ELEN_W-1:0] ELEN_MAX = ELEN_W'(WIDTH);
    localparam logic [WIDTH-1:0]  ONE_W    = WIDTH'(1);

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   x_r, x_s;
    logic [WIDTH-1:0]   m_r, m_s;
    logic [WIDTH-1:0]   e_r, e_s;
    logic [WIDTH-1:0]   acc_r, acc_s;
    logic [ELEN_W-1:0]  idx_r, idx_s;
    logic [WIDTH-1:0]   mm_a_r, mm_a_s;
    logic [WIDTH-1:0]   mm_b_r, mm_b_s;
    logic               mm_start_r, mm_start_s;
    logic [WIDTH-1:0]   result_r, result_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic [ELEN_W-1:0]  elen_clamp_s;
    logic               e_bit_s;

    // If the requested length exceeds the operand width, scan the full width.
    assign elen_clamp_s = (in_elen > ELEN_MAX) ? ELEN_MAX : in_elen;

    // This is the exponent bit for the position that was just squared.
    // idx_r has already been decremented at this point.
    assign e_bit_s = |(e_r & (ONE_W << idx_r));

    // Next-state logic and next values for every register.
    // Multiplier operands are loaded on the transition into a *_GO state, so
    // they appear together with the mm_start pulse and stay put through the wait.
    always_comb begin
        state_s    = state_r;
        x_s        = x_r;
        m_s        = m_r;
        e_s        = e_r;
        acc_s      = acc_r;
        idx_s      = idx_r;
        mm_a_s     = mm_a_r;
        mm_b_s     = mm_b_r;
        mm_start_s = 1'b0;
        result_s   = result_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    x_s     = in_x;
                    m_s     = in_m;
                    e_s     = in_e;
                    acc_s   = in_r;
                    idx_s   = elen_clamp_s;
                    state_s = ST_CHECK;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (idx_r == '0) begin
`ifdef MONT_EXP_FROMMONT_EN
                    mm_a_s     = acc_r;
                    mm_b_s     = ONE_W;
                    mm_start_s = 1'b1;
                    state_s    = ST_CONV_GO;
`else
                    state_s    = ST_FINAL;
`endif
                end else begin
                    idx_s      = idx_r - ELEN_W'(1);
                    mm_a_s     = acc_r;
                    mm_b_s     = acc_r;
                    mm_start_s = 1'b1;
                    state_s    = ST_SQ_GO;
                end
            end
            ST_SQ_GO: begin
                state_s = ST_SQ_WAIT;
            end
            ST_SQ_WAIT: begin
                if (mm_done) begin
                    acc_s = mm_result;
                    if (e_bit_s) begin
                        // acc is being updated on this same edge, so feed the fresh square through directly
                        mm_a_s     = mm_result;
                        mm_b_s     = x_r;
                        mm_start_s = 1'b1;
                        state_s    = ST_MUL_GO;
                    end else begin
                        state_s = ST_CHECK;
                    end
                end else begin
                    state_s = ST_SQ_WAIT;
                end
            end
            ST_MUL_GO: begin
                state_s = ST_MUL_WAIT;
            end
            ST_MUL_WAIT: begin
                if (mm_done) begin
                    acc_s   = mm_result;
                    state_s = ST_CHECK;
                end else begin
                    state_s = ST_MUL_WAIT;
                end
            end
`ifdef MONT_EXP_FROMMONT_EN
            ST_CONV_GO: begin
                state_s = ST_CONV_WAIT;
            end
            ST_CONV_WAIT: begin
                if (mm_done) begin
                    acc_s   = mm_result;
                    state_s = ST_FINAL;
                end else begin
                    state_s = ST_CONV_WAIT;
                end
            end
`endif
            ST_FINAL: begin
                result_s = acc_r;
                state_s  = ST_DONE;
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE) && (state_s != ST_DONE);
        done_s = (state_s == ST_DONE);
    end

    // State and output registers. Reset puts everything back to zero and idle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r    <= ST_IDLE;
            x_r        <= '0;
            m_r        <= '0;
            e_r        <= '0;
            acc_r      <= '0;
            idx_r      <= '0;
            mm_a_r     <= '0;
            mm_b_r     <= '0;
            mm_start_r <= 1'b0;
            result_r   <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            x_r        <= x_s;
            m_r        <= m_s;
            e_r        <= e_s;
            acc_r      <= acc_s;
            idx_r      <= idx_s;
            mm_a_r     <= mm_a_s;
            mm_b_r     <= mm_b_s;
            mm_start_r <= mm_start_s;
            result_r   <= result_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign mm_start = mm_start_r;
    assign mm_a     = mm_a_r;
    assign mm_b     = mm_b_r;
    assign mm_m     = m_r;
    assign result   = result_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Testbench for mont_exp_ctrl.
// A behavioural Montgomery multiplier answers calls after a random latency.
// Expected results come from plain modular exponentiation in the normal
// domain, converted to Montgomery form where the build requires it.
`timescale 1ns/1ps
module tb_mont_exp_ctrl;
    localparam int W  = 512;
    localparam int EW = 10;
    localparam int TW = 2 * W + 2;
`ifdef MONT_EXP_FROMMONT_EN
    localparam int CONV_CALLS = 1;
`else
    localparam int CONV_CALLS = 0;
`endif

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [W-1:0]  in_x, in_r, in_m, in_e;
    logic [EW-1:0] in_elen;
    logic          mm_start;
    logic [W-1:0]  mm_a, mm_b, mm_m;
    logic [W-1:0]  mm_result = '0;
    logic          mm_done = 1'b0;
    logic [W-1:0]  result;
    logic          busy, done;

    mont_exp_ctrl #(.WIDTH(W), .ELEN_W(EW)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .in_x(in_x), .in_r(in_r), .in_m(in_m), .in_e(in_e), .in_elen(in_elen),
        .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
        .mm_result(mm_result), .mm_done(mm_done),
        .result(result), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [W-1:0] q_a[$], q_b[$], q_m[$], q_res[$];
    logic         pend = 1'b0;
    logic [W-1:0] pa, pb, pm;
    int           lat_cnt;
    int           stab_err = 0;

    function automatic logic [W-1:0] rnd_w();
        logic [W-1:0] r = '0;
        for (int i = 0; i < W / 32; i++) r = (r << 32) | W'($urandom());
        return r;
    endfunction

    // Bit-serial Montgomery reduction: returns a*b*2^-W mod m.
    function automatic logic [W-1:0] redc(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
        logic [TW-1:0] t;
        t = TW'(a) * TW'(b);
        for (int i = 0; i < W; i++) begin
            if (t[0]) t = t + TW'(m);
            t = t >> 1;
        end
        if (t >= TW'(m)) t = t - TW'(m);
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] rmod(input logic [W-1:0] m);
        logic [TW-1:0] t;
        t = (TW'(1) << W) % TW'(m);
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] to_mont(input logic [W-1:0] v, input logic [W-1:0] m);
        logic [TW-1:0] t;
        t = (TW'(v) * TW'(rmod(m))) % TW'(m);
        return t[W-1:0];
    endfunction

    // Plain modular exponentiation x^e mod m over the low n exponent bits.
    function automatic logic [W-1:0] mod_exp(input logic [W-1:0] x, input logic [W-1:0] m, input logic [W-1:0] e, input int n);
        logic [TW-1:0] y, xx, mm;
        logic [W-1:0]  sh;
        mm = TW'(m);
        xx = TW'(x) % mm;
        y  = TW'(1) % mm;
        for (int i = n - 1; i >= 0; i--) begin
            y  = (y * y) % mm;
            sh = e >> i;
            if (sh[0]) y = (y * xx) % mm;
        end
        return y[W-1:0];
    endfunction

    function automatic int popc(input logic [W-1:0] e, input int n);
        int c = 0;
        logic [W-1:0] sh;
        for (int i = 0; i < n; i++) begin
            sh = e >> i;
            if (sh[0]) c++;
        end
        return c;
    endfunction

    // Multiplier model. It runs on the falling edge and logs every call.
    // It also checks that the operands stay stable while a call is pending.
    always @(negedge clk) begin
        mm_done   = 1'b0;
        mm_result = rnd_w();
        if (!resetn) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (mm_a !== pa || mm_b !== pb || mm_m !== pm) stab_err++;
                if (lat_cnt == 0) begin
                    mm_result = redc(pa, pb, pm);
                    q_res.push_back(mm_result);
                    mm_done = 1'b1;
                    pend    = 1'b0;
                end else begin
                    lat_cnt--;
                end
            end
            if (mm_start === 1'b1) begin
                pa = mm_a; pb = mm_b; pm = mm_m;
                q_a.push_back(mm_a); q_b.push_back(mm_b); q_m.push_back(mm_m);
                pend    = 1'b1;
                lat_cnt = $urandom_range(0, 3);
            end
        end
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic reset_dut();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    // Pulse start with the given operands, then scramble the inputs so that only captured values matter.
    task automatic launch(input logic [W-1:0] xm, input logic [W-1:0] rm, input logic [W-1:0] m,
                          input logic [W-1:0] e, input logic [EW-1:0] el);
        q_a.delete(); q_b.delete(); q_m.delete(); q_res.delete();
        stab_err = 0;
        in_x = xm; in_r = rm; in_m = m; in_e = e; in_elen = el;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        in_x = rnd_w(); in_r = rnd_w(); in_m = rnd_w(); in_e = rnd_w(); in_elen = EW'($urandom());
    endtask

    task automatic wait_done(input int maxc, output int lat, output bit to);
        lat = 1;
        to  = 1'b0;
        while (done !== 1'b1) begin
            if (lat >= maxc) begin
                to = 1'b1;
                break;
            end
            @(posedge clk);
            #1 lat++;
        end
    endtask

    // Check the logged call sequence. The expected order comes from scanning the exponent MSB first:
    // one square per bit, then a multiply by x when the bit is set.
    task automatic verify_calls(input string nm, input logic [W-1:0] xm, input logic [W-1:0] rm,
                                input logic [W-1:0] m, input logic [W-1:0] e, input int eff);
        byte          kind[$];
        logic [W-1:0] sh, a_exp, b_exp;
        int           n;
        for (int i = eff - 1; i >= 0; i--) begin
            kind.push_back("S");
            sh = e >> i;
            if (sh[0]) kind.push_back("M");
        end
`ifdef MONT_EXP_FROMMONT_EN
        kind.push_back("C");
`endif
        chk({nm, ".seqlen"}, W'(q_a.size()), W'(kind.size()));
        n     = (q_a.size() < kind.size()) ? q_a.size() : kind.size();
        a_exp = rm;
        for (int k = 0; k < n; k++) begin
            case (kind[k])
                "S":     b_exp = a_exp;
                "M":     b_exp = xm;
                default: b_exp = W'(1);
            endcase
            chk($sformatf("%s.call%0d.a", nm, k), q_a[k], a_exp);
            chk($sformatf("%s.call%0d.b", nm, k), q_b[k], b_exp);
            chk($sformatf("%s.call%0d.m", nm, k), q_m[k], m);
            a_exp = (k < q_res.size()) ? q_res[k] : '0;
        end
    endtask

    task automatic finish_check(input string nm, input logic [W-1:0] xm, input logic [W-1:0] rm,
                                input logic [W-1:0] m, input logic [W-1:0] e, input int eff,
                                input logic [W-1:0] exp_norm, input int exp_calls, input int exp_lat);
        int           lat;
        bit           to;
        logic [W-1:0] exp_res;
        wait_done((exp_calls + 1) * 10 + 20, lat, to);
        chk({nm, ".timeout"}, W'(to), '0);
        if (to) begin
            reset_dut();
        end else begin
`ifdef MONT_EXP_FROMMONT_EN
            exp_res = exp_norm;
`else
            exp_res = to_mont(exp_norm, m);
`endif
            chk({nm, ".result"}, result, exp_res);
            chk({nm, ".busy_at_done"}, W'(busy), '0);
            if (exp_lat > 0) chk({nm, ".latency"}, W'(lat), W'(exp_lat));
            @(posedge clk);
            #1 chk({nm, ".done_pulse"}, W'(done), '0);
            verify_calls(nm, xm, rm, m, e, eff);
            chk({nm, ".ncalls"}, W'(q_a.size()), W'(exp_calls));
            chk({nm, ".hold"}, W'(stab_err), '0);
        end
    endtask

    task automatic run_check(input string nm, input logic [W-1:0] x, input logic [W-1:0] m,
                             input logic [W-1:0] e, input logic [EW-1:0] el,
                             input logic [W-1:0] exp_norm, input int exp_calls, input int exp_lat);
        logic [W-1:0] xm, rm;
        int           eff;
        eff = (el > EW'(W)) ? W : int'(el);
        rm  = rmod(m);
        xm  = to_mont(x, m);
        launch(xm, rm, m, e, el);
        chk({nm, ".busy"}, W'(busy), W'(1));
        finish_check(nm, xm, rm, m, e, eff, exp_norm, exp_calls, exp_lat);
    endtask

    typedef struct {
        logic [W-1:0]  x;
        logic [W-1:0]  m;
        logic [W-1:0]  e;
        logic [EW-1:0] elen;
        logic [W-1:0]  y;
        int            calls;
    } vec_t;

    vec_t         vt[3];
    logic [W-1:0] rx, rm_, re, rx2, rxm, rrm;
    logic [EW-1:0] rel;
    int           eff, n;

    initial begin
        // Directed vectors: y is x^e mod m in the normal domain; calls excludes the conversion call.
        vt[0] = '{x: W'(5), m: W'(13), e: W'(0), elen: EW'(0), y: W'(1), calls: 0};
        vt[1] = '{x: W'(7), m: W'(13), e: W'(1), elen: EW'(1), y: W'(7), calls: 2};
        vt[2] = '{x: W'(2), m: W'(13), e: W'(5), elen: EW'(3), y: W'(6), calls: 5};

        resetn = 1'b0; start = 1'b0;
        in_x = '0; in_r = '0; in_m = '0; in_e = '0; in_elen = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", W'(busy), '0);
        chk("rst.done", W'(done), '0);
        chk("rst.mm_start", W'(mm_start), '0);
        chk("rst.result", result, '0);
        chk("rst.mm_a", mm_a, '0);
        chk("rst.mm_b", mm_b, '0);
        chk("rst.mm_m", mm_m, '0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++)
            run_check($sformatf("vec%0d", i), vt[i].x, vt[i].m, vt[i].e, vt[i].elen, vt[i].y,
                      vt[i].calls + CONV_CALLS, (vt[i].elen == EW'(0) && CONV_CALLS == 0) ? 3 : 0);

        // Random short runs with full-width odd moduli.
        for (int i = 0; i < 5; i++) begin
            rm_ = rnd_w() | W'(1);
            rm_[W-1] = 1'b1;
            rx  = rnd_w() % rm_;
            re  = rnd_w();
            rel = EW'($urandom_range(0, 24));
            eff = int'(rel);
            run_check($sformatf("rnd%0d", i), rx, rm_, re, rel, mod_exp(rx, rm_, re, eff),
                      eff + popc(re, eff) + CONV_CALLS, 0);
        end

        // Full-length exponent of all ones, then a length above WIDTH that must clamp.
        for (int i = 0; i < 2; i++) begin
            rm_ = rnd_w() | W'(1);
            rm_[W-1] = 1'b1;
            rx  = rnd_w() % rm_;
            re  = (i == 0) ? ~W'(0) : rnd_w();
            rel = (i == 0) ? EW'(512) : EW'(700);
            run_check((i == 0) ? "full" : "clamp", rx, rm_, re, rel, mod_exp(rx, rm_, re, W),
                      W + popc(re, W) + CONV_CALLS, 0);
        end

        // Start pulsed during SQ_WAIT with different operands must be ignored.
        rm_ = rnd_w() | W'(1);
        rm_[W-1] = 1'b1;
        rx  = rnd_w() % rm_;
        re  = rnd_w();
        rxm = to_mont(rx, rm_);
        rrm = rmod(rm_);
        launch(rxm, rrm, rm_, re, EW'(8));
        n = 0;
        while (q_a.size() < 1 && n < 50) begin
            @(negedge clk);
            #1 n++;
        end
        chk("busystart.reach_sq", W'(q_a.size()), W'(1));
        @(posedge clk);
        #1;
        rx2 = rnd_w() % rm_;
        in_x = to_mont(rx2, rm_); in_r = rrm; in_m = rm_; in_e = ~re; in_elen = EW'(8);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busystart.busy", W'(busy), W'(1));
        finish_check("busystart", rxm, rrm, rm_, re, 8, mod_exp(rx, rm_, re, 8),
                     8 + popc(re, 8) + CONV_CALLS, 0);

        // Reset asserted for one cycle while a multiply is outstanding.
        rm_ = rnd_w() | W'(1);
        rm_[W-1] = 1'b1;
        rx  = rnd_w() % rm_;
        launch(to_mont(rx, rm_), rmod(rm_), rm_, W'(1), EW'(1));
        n = 0;
        while (q_a.size() < 2 && n < 50) begin
            @(negedge clk);
            #1 n++;
        end
        chk("midrst.reach_mul", W'(q_a.size()), W'(2));
        @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst.busy", W'(busy), '0);
        chk("midrst.done", W'(done), '0);
        chk("midrst.result", result, '0);
        chk("midrst.mm_start", W'(mm_start), '0);
        chk("midrst.mm_a", mm_a, '0);
        chk("midrst.mm_m", mm_m, '0);
        resetn = 1'b1;
        q_a.delete();
        repeat (6) @(posedge clk);
        #1;
        chk("midrst.no_restart", W'(q_a.size()), '0);
        chk("midrst.idle_busy", W'(busy), '0);
        run_check("after_rst", vt[2].x, vt[2].m, vt[2].e, vt[2].elen, vt[2].y, vt[2].calls + CONV_CALLS, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
